// File: rtl/line_buf_pkg.sv
// rtl/line_buf_pkg.sv - shared widths and bank-state encoding for the line-buffer scheduler
package line_buf_pkg;
   localparam int LB_AW = 6;
   localparam int LB_DW = 30;

   typedef enum logic [1:0] {
      BANK_EMPTY    = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_state_e;

   function automatic logic bank_writable(input bank_state_e s);
      return (s == BANK_EMPTY) || (s == BANK_FILLING);
   endfunction
endpackage

// File: rtl/line_buf_bank_sched_if.sv
// rtl/line_buf_bank_sched_if.sv - video writer/reader handshake plus both SRAM port buses
interface line_buf_bank_sched_if
   import line_buf_pkg::*;
#(
   parameter int AW = LB_AW,
   parameter int DW = LB_DW
);
   logic          i_frame_start;
   logic [AW-1:0] i_hact;
   logic          i_wr_valid;
   logic [DW-1:0] i_wr_data;
   logic          o_wr_ready;
   logic          i_rd_req;
   logic          o_rd_valid;
   logic [DW-1:0] o_rd_data;
   logic          o_rd_last;
   logic          o_ovf;
   logic          o_udf;
   logic          o_cs1;
   logic          o_we1;
   logic [AW-1:0] o_addr1;
   logic [DW-1:0] o_din1;
   logic [DW-1:0] i_dout1;
   logic          o_cs2;
   logic          o_we2;
   logic [AW-1:0] o_addr2;
   logic [DW-1:0] o_din2;
   logic [DW-1:0] i_dout2;

   modport slave (
      input  i_frame_start, i_hact, i_wr_valid, i_wr_data, i_rd_req, i_dout1, i_dout2,
      output o_wr_ready, o_rd_valid, o_rd_data, o_rd_last, o_ovf, o_udf,
      output o_cs1, o_we1, o_addr1, o_din1, o_cs2, o_we2, o_addr2, o_din2
   );

   modport master (
      output i_frame_start, i_hact, i_wr_valid, i_wr_data, i_rd_req, i_dout1, i_dout2,
      input  o_wr_ready, o_rd_valid, o_rd_data, o_rd_last, o_ovf, o_udf,
      input  o_cs1, o_we1, o_addr1, o_din1, o_cs2, o_we2, o_addr2, o_din2
   );
endinterface

// File: rtl/line_buf_bank_fsm.sv
// rtl/line_buf_bank_fsm.sv - lifecycle of one line bank: empty, filling, full, draining
module line_buf_bank_fsm
   import line_buf_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        wr_start,
   input  logic        wr_done,
   input  logic        rd_start,
   input  logic        rd_done,
   output bank_state_e state
);
   // wr_done wins over wr_start so a one-pixel line goes straight to FULL
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BANK_EMPTY;
      end else if (flush) begin
         state <= BANK_EMPTY;
      end else begin
         case (state)
            BANK_EMPTY: begin
               if (wr_done)       state <= BANK_FULL;
               else if (wr_start) state <= BANK_FILLING;
            end
            BANK_FILLING:  if (wr_done)  state <= BANK_FULL;
            BANK_FULL:     if (rd_start) state <= BANK_DRAINING;
            BANK_DRAINING: if (rd_done)  state <= BANK_EMPTY;
            default:       state <= BANK_EMPTY;
         endcase
      end
   end
endmodule

// File: rtl/line_buf_bank_sched.sv
// rtl/line_buf_bank_sched.sv - ping-pong write/read scheduler over two single-port line SRAMs
module line_buf_bank_sched
   import line_buf_pkg::*;
#(
   parameter int AW = LB_AW,
   parameter int DW = LB_DW
)(
   input logic                  clk,
   input logic                  rst_n,
   line_buf_bank_sched_if.slave bus
);
   bank_state_e   st0, st1, wr_st, rd_st;
   logic          wr_bank, rd_bank;
   logic [AW-1:0] wr_addr, rd_addr, hact_q, last_addr;
   logic          rd_valid, rd_last, rd_sel, ovf, udf;
   logic          fs, wr_beat, wr_done, rd_accept, rd_issue, rd_done;
   logic          w0, w1, r0, r1;

   assign fs        = bus.i_frame_start;
   // hact_q of 0 wraps to all-ones, giving a full 2**AW pixel line
   assign last_addr = hact_q - AW'(1);
   assign wr_st     = wr_bank ? st1 : st0;
   assign rd_st     = rd_bank ? st1 : st0;

   assign bus.o_wr_ready = bank_writable(wr_st);
   assign wr_beat   = bus.i_wr_valid & bus.o_wr_ready & ~fs;
   assign wr_done   = wr_beat & (wr_addr == last_addr);
   assign rd_accept = bus.i_rd_req & (rd_st == BANK_FULL) & ~fs;
   assign rd_issue  = (rd_st == BANK_DRAINING) & ~fs;
   assign rd_done   = rd_issue & (rd_addr == last_addr);

   line_buf_bank_fsm u_bank0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (fs),
      .wr_start (wr_beat & ~wr_bank),
      .wr_done  (wr_done & ~wr_bank),
      .rd_start (rd_accept & ~rd_bank),
      .rd_done  (rd_done & ~rd_bank),
      .state    (st0)
   );

   line_buf_bank_fsm u_bank1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (fs),
      .wr_start (wr_beat & wr_bank),
      .wr_done  (wr_done & wr_bank),
      .rd_start (rd_accept & rd_bank),
      .rd_done  (rd_done & rd_bank),
      .state    (st1)
   );

   // write and read target different banks by construction, so each port sees at most one access
   assign w0 = wr_beat & ~wr_bank;
   assign w1 = wr_beat & wr_bank;
   assign r0 = rd_issue & ~rd_bank;
   assign r1 = rd_issue & rd_bank;

   assign bus.o_cs1   = w0 | r0;
   assign bus.o_we1   = w0;
   assign bus.o_addr1 = w0 ? wr_addr : rd_addr;
   assign bus.o_din1  = bus.i_wr_data;
   assign bus.o_cs2   = w1 | r1;
   assign bus.o_we2   = w1;
   assign bus.o_addr2 = w1 ? wr_addr : rd_addr;
   assign bus.o_din2  = bus.i_wr_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b0;
         wr_addr  <= '0;
         rd_addr  <= '0;
         hact_q   <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_sel   <= 1'b0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
      end else if (fs) begin
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b0;
         wr_addr  <= '0;
         rd_addr  <= '0;
         hact_q   <= bus.i_hact;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_sel   <= 1'b0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
      end else begin
         if (wr_beat) begin
            wr_addr <= wr_done ? '0 : wr_addr + 1'b1;
            if (wr_done) wr_bank <= ~wr_bank;
         end
         if (rd_accept)     rd_addr <= '0;
         else if (rd_issue) rd_addr <= rd_done ? '0 : rd_addr + 1'b1;
         if (rd_done) rd_bank <= ~rd_bank;
         rd_valid <= rd_issue;
         rd_last  <= rd_done;
         rd_sel   <= rd_bank;
         ovf      <= bus.i_wr_valid & ~bus.o_wr_ready;
         udf      <= bus.i_rd_req & (rd_st != BANK_FULL) & (rd_st != BANK_DRAINING);
      end
   end

   assign bus.o_rd_valid = rd_valid;
   assign bus.o_rd_last  = rd_last;
   assign bus.o_rd_data  = rd_valid ? (rd_sel ? bus.i_dout2 : bus.i_dout1) : {DW{1'b0}};
   assign bus.o_ovf      = ovf;
   assign bus.o_udf      = udf;
endmodule

// File: tb/tb_line_buf_bank_sched.sv
// tb/tb_line_buf_bank_sched.sv - directed bench with a line-level reference model of the scheduler
module tb_line_buf_bank_sched;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   line_buf_bank_sched_if #(.AW(6), .DW(30)) bus ();

   line_buf_bank_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // behavioural single-port SRAMs, dout one cycle after a read select
   logic [29:0] mem1 [64];
   logic [29:0] mem2 [64];
   always @(posedge clk) begin
      if (bus.o_cs1) begin
         if (bus.o_we1) mem1[bus.o_addr1] <= bus.o_din1;
         else           bus.i_dout1 <= mem1[bus.o_addr1];
      end
      if (bus.o_cs2) begin
         if (bus.o_we2) mem2[bus.o_addr2] <= bus.o_din2;
         else           bus.i_dout2 <= mem2[bus.o_addr2];
      end
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // reference model: bank occupancy, stored lines and a timeline of expected read beats
   typedef struct {
      int          c;
      logic [29:0] d;
      bit          last;
   } rd_beat_t;

   int          m_st [2];   // 0 empty, 1 filling, 2 full, 3 draining
   int          m_rstart [2];
   int          m_wp, m_rp, m_wcnt, m_hact;
   logic [29:0] m_line [2][64];
   rd_beat_t    m_q [$];
   bit          m_ovf, m_udf;

   logic [29:0] got_rd [$];
   int          n_last, n_ovf, n_udf;
   logic [29:0] last_data;

   task automatic model_clear();
      for (int b = 0; b < 2; b++) begin
         m_st[b]     = 0;
         m_rstart[b] = 0;
      end
      m_wp = 0; m_rp = 0; m_wcnt = 0;
      m_q.delete();
      m_ovf = 0; m_udf = 0;
   endtask

   always @(negedge clk) begin : check_p
      bit          e_wr_ready, fs, wbeat, ev, el;
      bit          e_cs [2];
      bit          e_we [2];
      int          e_addr [2];
      logic [29:0] ed;
      int          acc_b;
      cyc++;
      if (!rst_n) begin
         model_clear();
         m_hact = 64;
      end
      e_wr_ready = (m_st[m_wp] <= 1);
      fs         = bus.i_frame_start;
      wbeat      = bus.i_wr_valid && e_wr_ready && !fs;
      for (int b = 0; b < 2; b++) begin
         e_cs[b] = 0; e_we[b] = 0; e_addr[b] = 0;
         if (m_st[b] == 3 && !fs) begin
            e_cs[b]   = 1;
            e_addr[b] = cyc - m_rstart[b] - 1;
         end
      end
      if (wbeat) begin
         e_cs[m_wp] = 1; e_we[m_wp] = 1; e_addr[m_wp] = m_wcnt;
      end
      ev = 0; ed = '0; el = 0;
      if (m_q.size() > 0 && m_q[0].c == cyc) begin
         ev = 1; ed = m_q[0].d; el = m_q[0].last;
         void'(m_q.pop_front());
      end

      chk("wr_ready", bus.o_wr_ready, e_wr_ready);
      chk("cs1", bus.o_cs1, e_cs[0]);
      chk("we1", bus.o_we1, e_we[0]);
      chk("cs2", bus.o_cs2, e_cs[1]);
      chk("we2", bus.o_we2, e_we[1]);
      if (e_cs[0]) chk("addr1", bus.o_addr1, e_addr[0]);
      if (e_cs[1]) chk("addr2", bus.o_addr2, e_addr[1]);
      if (e_we[0]) chk("din1", bus.o_din1, bus.i_wr_data);
      if (e_we[1]) chk("din2", bus.o_din2, bus.i_wr_data);
      chk("rd_valid", bus.o_rd_valid, ev);
      chk("rd_data", bus.o_rd_data, ed);
      chk("rd_last", bus.o_rd_last, el);
      chk("ovf", bus.o_ovf, m_ovf);
      chk("udf", bus.o_udf, m_udf);

      if (bus.o_rd_valid) got_rd.push_back(bus.o_rd_data);
      if (bus.o_rd_last) begin n_last++; last_data = bus.o_rd_data; end
      if (bus.o_ovf) n_ovf++;
      if (bus.o_udf) n_udf++;

      if (rst_n) begin
         m_ovf = bus.i_wr_valid && !e_wr_ready && !fs;
         m_udf = bus.i_rd_req && !fs && (m_st[m_rp] < 2);
         if (fs) begin
            model_clear();
            m_hact = (bus.i_hact == 0) ? 64 : int'(bus.i_hact);
         end else begin
            acc_b = (bus.i_rd_req && m_st[m_rp] == 2) ? m_rp : -1;
            for (int b = 0; b < 2; b++)
               if (m_st[b] == 3 && cyc == m_rstart[b] + m_hact) begin
                  m_st[b] = 0;
                  m_rp ^= 1;
               end
            if (acc_b >= 0) begin
               m_st[acc_b]     = 3;
               m_rstart[acc_b] = cyc;
               for (int k = 0; k < m_hact; k++)
                  m_q.push_back('{cyc + 2 + k, m_line[acc_b][k], (k == m_hact - 1)});
            end
            if (wbeat) begin
               m_line[m_wp][m_wcnt] = bus.i_wr_data;
               m_st[m_wp] = 1;
               m_wcnt++;
               if (m_wcnt == m_hact) begin
                  m_st[m_wp] = 2;
                  m_wcnt = 0;
                  m_wp ^= 1;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.i_wr_valid = 0; bus.i_rd_req = 0; bus.i_frame_start = 0;
      repeat (n) tick();
   endtask

   task automatic frame(input logic [5:0] h);
      bus.i_frame_start = 1; bus.i_hact = h;
      tick();
      bus.i_frame_start = 0;
   endtask

   task automatic wr(input logic [29:0] d, input bit req);
      bus.i_wr_valid = 1; bus.i_wr_data = d; bus.i_rd_req = req;
      tick();
      bus.i_wr_valid = 0; bus.i_rd_req = 0;
   endtask

   task automatic rd();
      bus.i_rd_req = 1;
      tick();
      bus.i_rd_req = 0;
   endtask

   task automatic clear_log();
      got_rd.delete();
      n_last = 0; n_ovf = 0; n_udf = 0; last_data = '0;
   endtask

   initial begin
      rst_n = 0;
      bus.i_frame_start = 0; bus.i_hact = '0; bus.i_wr_valid = 0;
      bus.i_wr_data = '0; bus.i_rd_req = 0;
      clear_log();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      chk("reset wr_ready", bus.o_wr_ready, 1'b1);
      chk("reset rd_valid", bus.o_rd_valid, 1'b0);
      idle(1);

      // 1: single 4-pixel line through SRAM1
      frame(6'd4);
      clear_log();
      for (int k = 1; k <= 4; k++) wr(30'(k), 0);
      rd();
      idle(8);
      chk("t1 count", got_rd.size(), 4);
      for (int k = 0; k < 4 && k < got_rd.size(); k++) chk("t1 data", got_rd[k], 30'(k + 1));
      chk("t1 last", last_data, 30'h4);
      chk("t1 nlast", n_last, 1);

      // 2: line B written back-to-back while line A drains
      frame(6'd4);
      clear_log();
      for (int k = 0; k < 4; k++) wr(30'h11 + 30'(k), 0);
      for (int k = 0; k < 4; k++) wr(30'h21 + 30'(k), k == 0);
      idle(6);
      rd();
      idle(7);
      chk("t2 count", got_rd.size(), 8);
      if (got_rd.size() == 8) begin
         chk("t2 a0", got_rd[0], 30'h11);
         chk("t2 a3", got_rd[3], 30'h14);
         chk("t2 b0", got_rd[4], 30'h21);
         chk("t2 b3", got_rd[7], 30'h24);
      end

      // 3: third line with both banks full is dropped
      frame(6'd4);
      clear_log();
      for (int k = 0; k < 12; k++) wr(30'h31 + 30'(k), 0);
      idle(2);
      chk("t3 novf", n_ovf, 4);
      rd();
      idle(6);
      rd();
      idle(7);
      chk("t3 count", got_rd.size(), 8);
      if (got_rd.size() == 8) begin
         chk("t3 l1", got_rd[0], 30'h31);
         chk("t3 l2", got_rd[7], 30'h38);
      end

      // 4: read request straight after reset underflows
      rst_n = 0;
      idle(2);
      rst_n = 1;
      clear_log();
      rd();
      idle(3);
      chk("t4 nudf", n_udf, 1);
      chk("t4 no rd", got_rd.size(), 0);

      // 5: frame start mid-drain squashes the read and applies the new width
      frame(6'd4);
      clear_log();
      for (int k = 0; k < 4; k++) wr(30'h51 + 30'(k), 0);
      rd();
      idle(2);
      frame(6'd8);
      chk("t5 wr_ready", bus.o_wr_ready, 1'b1);
      idle(3);
      chk("t5 squashed", got_rd.size(), 2);
      chk("t5 nlast", n_last, 0);
      clear_log();
      for (int k = 0; k < 8; k++) wr(30'h61 + 30'(k), 0);
      rd();
      idle(11);
      chk("t5 count", got_rd.size(), 8);
      chk("t5 last", last_data, 30'h68);

      // 6: hact of 0 means a 64-pixel line, then a reset mid-line
      frame(6'd0);
      clear_log();
      for (int k = 0; k < 64; k++) wr(30'h100 + 30'(k), 0);
      chk("t6 full", bus.o_wr_ready, 1'b1);
      wr(30'h200, 1);
      wr(30'h201, 0);
      idle(68);
      chk("t6 count", got_rd.size(), 64);
      if (got_rd.size() == 64) begin
         chk("t6 first", got_rd[0], 30'h100);
         chk("t6 end", got_rd[63], 30'h13f);
      end
      chk("t6 last", last_data, 30'h13f);
      rst_n = 0;
      idle(2);
      rst_n = 1;
      idle(1);
      chk("t6 rst wr_ready", bus.o_wr_ready, 1'b1);
      chk("t6 rst rd_valid", bus.o_rd_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
